nnet_vector_framer: RTL and testbench
=====================================

NNET_VECTOR_FRAMER -- requirements
Module: nnet_vector_framer

Interface
REQ-001 Parameter DATA_W, default 18: width of the sample bus to/from the HLS neural-net core (1..32).
REQ-002 Parameter SIGN_EXT, default 1: 1 = sign-extend core results to 32 bits, 0 = zero-fill.
REQ-003 Parameter SR_USER_SPP, default 131: settings address of the output samples-per-packet register.
REQ-004 Parameter SR_MODE, default 132: settings address of the mode register (bit0 = bypass).
REQ-005 Port clk input 1: single clock for the whole block (ce_clk domain).
REQ-006 Port reset input 1: synchronous, active-high reset.
REQ-007 Port clear input 1: synchronous flush (clear_tx_seqnum).
REQ-008 Ports set_stb input 1, set_addr input 8, set_data input 32: settings bus.
REQ-009 Ports nnet_size_in input 16, nnet_size_out input 16: vector lengths N_IN and N_OUT reported by the core.
REQ-010 Ports i_tdata input 32, i_tlast input 1, i_tvalid input 1, i_tready output 1, i_tuser input 128: stream from axi_wrapper.
REQ-011 Ports o_tdata output 32, o_tlast output 1, o_tvalid output 1, o_tready input 1, o_tuser output 128: stream to axi_wrapper.
REQ-012 Ports m_axis_tdata output DATA_W, m_axis_tlast output 1, m_axis_tvalid output 1, m_axis_tready input 1: samples to the core.
REQ-013 Ports s_axis_tdata input DATA_W, s_axis_tvalid input 1, s_axis_tready output 1: results from the core (no tlast).
REQ-014 Ports spp_out output 16, vec_in_cnt output 16, vec_out_cnt output 16: readback values.

Function
REQ-015 Settings writes to SR_USER_SPP and SR_MODE land in shadow registers on set_stb; the active copies update only when both the input-side and output-side counters are zero.
REQ-016 N_IN and N_OUT are latched at each vector start; a value of 0 is treated as 1.
REQ-017 The input path is combinational: m_axis_tdata = i_tdata[DATA_W-1:0], m_axis_tvalid = i_tvalid & in_ok, i_tready = m_axis_tready & in_ok.
REQ-018 in_ok is 0 only when in_cnt==0 and the header FIFO is full; otherwise it is 1.
REQ-019 i_tlast is ignored for framing; m_axis_tlast is asserted on the transfer where in_cnt==N_IN-1.
REQ-020 On the first transfer of a vector (in_cnt==0), i_tuser is pushed into a 2-entry header FIFO.
REQ-021 in_cnt increments per accepted input transfer and wraps to 0 after N_IN-1; vec_in_cnt increments (mod 2^16) on each wrap.
REQ-022 Output path: o_tvalid = s_axis_tvalid & hdr_nonempty, s_axis_tready = o_tready & hdr_nonempty.
REQ-023 o_tdata is s_axis_tdata extended to 32 bits according to SIGN_EXT.
REQ-024 Two counters, pkt_cnt and vec_cnt, increment per output transfer.
REQ-025 o_tlast = (pkt_cnt==SPP-1) | (vec_cnt==N_OUT-1); pkt_cnt clears on o_tlast; SPP=0 means SPP=N_OUT.
REQ-026 o_tuser = header-FIFO head, with EOB bit 124 forced to 1 only on the packet containing vec_cnt==N_OUT-1 and forced to 0 otherwise; all other bits pass through.
REQ-027 When vec_cnt wraps, the header is popped and vec_out_cnt increments.
REQ-028 A simultaneous push and pop on a full FIFO is legal: in_ok evaluates as 1 in that cycle.
REQ-029 Bypass mode (active bit0=1) connects i_* to o_* directly (tdata, tlast, tvalid, tuser, tready); m_axis_tvalid=0, s_axis_tready=0, and the counters hold.
REQ-030 spp_out = active SPP.
REQ-031 clear zeroes in_cnt, pkt_cnt, vec_cnt, vec_in_cnt and vec_out_cnt and empties the header FIFO; settings registers retain their values.

Reset
REQ-032 Reset values: all counters 0, header FIFO empty, SPP=0 (shadow and active), mode=0.
REQ-033 Outputs during reset: o_tvalid=0, m_axis_tvalid=0, i_tready=0, s_axis_tready=0, o_tlast=0, m_axis_tlast=0.
REQ-034 Reset asserted mid-vector discards partial vectors and headers with no further output; the first accepted sample after reset starts a new vector.

Structure
REQ-035 The CHDR tuser field positions (EOB bit 124, header [127:64], time [63:0]) and the SR_* defaults belong in a shared nnet_pkg package.
REQ-036 The 2-entry, 128-bit header FIFO is a sub-module named nnet_hdr_fifo, with synchronous reset and a clear input.

Verification
REQ-037 Scenario 1: N_IN=8, N_OUT=4, SPP=0; input packets of 5 samples, values 0..15. Required: m_axis_tlast on samples 7 and 15; two output packets of 4 samples; EOB set in each; headers equal the tuser of input samples 0 and 8.
REQ-038 Scenario 2: N_OUT=10, SPP=4. Required: output packets of 4, 4 and 2 samples; EOB set only on the packet of 2.
REQ-039 Scenario 3: core result 18'h3FFFF. Required: SIGN_EXT=1 gives o_tdata=32'hFFFFFFFF; SIGN_EXT=0 gives 32'h0003FFFF.
REQ-040 Scenario 4: o_tready=0 while three input vectors are offered. Required: the third vector's first sample is stalled (i_tready=0) until one output vector drains.
REQ-041 Scenario 5: SPP written mid-vector. Required: the new SPP takes effect only from the next vector.
REQ-042 Scenario 6: clear or reset pulsed after 3 of 8 input samples. Required: counters read 0, no output is produced, and the next 8 samples form a complete vector.

Source files
------------

// File: rtl/nnet_pkg.sv
// nnet_pkg: CHDR tuser field positions, settings-register defaults and small helpers shared by the framer.
package nnet_pkg;
  localparam int EOB_BIT = 124;
  localparam int HDR_HI = 127;
  localparam int HDR_LO = 64;
  localparam int TIME_HI = 63;
  localparam int TIME_LO = 0;
  localparam int SR_USER_SPP_DEF = 131;
  localparam int SR_MODE_DEF = 132;
  typedef logic [127:0] tuser_t;
  function automatic logic [15:0] nz(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction
  function automatic tuser_t set_eob(input tuser_t u, input logic eob);
    tuser_t r;
    r = {u[HDR_HI:HDR_LO], u[TIME_HI:TIME_LO]};
    r[EOB_BIT] = eob;
    return r;
  endfunction
endpackage

// File: rtl/nnet_hdr_fifo.sv
// nnet_hdr_fifo: 2-entry header FIFO; a push while full is legal only together with a pop.
module nnet_hdr_fifo
  import nnet_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [127:0] din,
  input  logic         pop,
  output logic [127:0] dout,
  output logic         full,
  output logic         nonempty
);
  tuser_t mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] cnt;
  assign dout = mem[rd_ptr];
  assign full = cnt == 2'd2;
  assign nonempty = cnt != 2'd0;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/nnet_vector_framer.sv
// nnet_vector_framer: frames a sample stream into N_IN-sample vectors for an HLS net core and
// re-packetises its N_OUT-sample results into SPP-sized CHDR packets carrying the input header.
module nnet_vector_framer
  import nnet_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int SIGN_EXT = 1,
  parameter int SR_USER_SPP = SR_USER_SPP_DEF,
  parameter int SR_MODE = SR_MODE_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [15:0]       nnet_size_in,
  input  logic [15:0]       nnet_size_out,
  input  logic [31:0]       i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  input  logic [127:0]      i_tuser,
  output logic [31:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [127:0]      o_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [15:0]       spp_out,
  output logic [15:0]       vec_in_cnt,
  output logic [15:0]       vec_out_cnt
);
  logic [15:0] spp_sh, spp_act, in_cnt, pkt_cnt, vec_cnt, n_in_lat, n_out_lat, n_in, n_out, spp;
  logic mode_sh, mode_act, run, byp, idle;
  logic hdr_full, hdr_ne, in_ok, in_xfer, out_xfer, pop, last_in, last_out, eob_pkt;
  logic [127:0] hdr;
  logic unused_bits;
  assign unused_bits = ^{set_data, i_tdata};
  assign run = ~reset;
  assign byp = mode_act;
  assign idle = in_cnt == 16'd0 && vec_cnt == 16'd0 && !hdr_ne;
  assign n_in = (in_cnt == 16'd0) ? nz(nnet_size_in) : n_in_lat;
  assign n_out = (vec_cnt == 16'd0) ? nz(nnet_size_out) : n_out_lat;
  assign spp = (spp_act == 16'd0) ? n_out : spp_act;
  assign last_in = in_cnt == n_in - 16'd1;
  assign last_out = vec_cnt == n_out - 16'd1;
  // the current packet holds the vector's last sample when what remains fits in what the packet has left
  assign eob_pkt = (n_out - vec_cnt) <= (spp - pkt_cnt);
  assign out_xfer = run & ~byp & s_axis_tvalid & o_tready & hdr_ne;
  assign pop = out_xfer & last_out;
  assign in_ok = ~(in_cnt == 16'd0 && hdr_full) | pop;
  assign in_xfer = run & ~byp & i_tvalid & m_axis_tready & in_ok;
  assign m_axis_tdata = i_tdata[DATA_W-1:0];
  assign m_axis_tvalid = run & ~byp & i_tvalid & in_ok;
  assign m_axis_tlast = run & ~byp & last_in;
  assign s_axis_tready = run & ~byp & o_tready & hdr_ne;
  assign i_tready = run & (byp ? o_tready : m_axis_tready & in_ok);
  assign o_tvalid = run & (byp ? i_tvalid : s_axis_tvalid & hdr_ne);
  assign o_tlast = run & (byp ? i_tlast : (pkt_cnt == spp - 16'd1) | last_out);
  assign o_tdata = byp ? i_tdata : (SIGN_EXT != 0) ? 32'(signed'(s_axis_tdata)) : 32'(s_axis_tdata);
  assign o_tuser = byp ? i_tuser : set_eob(hdr, eob_pkt);
  assign spp_out = spp_act;
  nnet_hdr_fifo u_hdr_fifo (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .push(in_xfer & (in_cnt == 16'd0)),
    .din(i_tuser),
    .pop(pop),
    .dout(hdr),
    .full(hdr_full),
    .nonempty(hdr_ne)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      spp_sh <= 16'd0;
      spp_act <= 16'd0;
      mode_sh <= 1'b0;
      mode_act <= 1'b0;
    end else begin
      if (set_stb && set_addr == 8'(SR_USER_SPP)) spp_sh <= set_data[15:0];
      if (set_stb && set_addr == 8'(SR_MODE)) mode_sh <= set_data[0];
      if (idle) begin
        spp_act <= spp_sh;
        mode_act <= mode_sh;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      in_cnt <= 16'd0;
      pkt_cnt <= 16'd0;
      vec_cnt <= 16'd0;
      vec_in_cnt <= 16'd0;
      vec_out_cnt <= 16'd0;
      n_in_lat <= 16'd1;
      n_out_lat <= 16'd1;
    end else begin
      if (in_xfer) begin
        in_cnt <= last_in ? 16'd0 : in_cnt + 16'd1;
        if (in_cnt == 16'd0) n_in_lat <= n_in;
        if (last_in) vec_in_cnt <= vec_in_cnt + 16'd1;
      end
      if (out_xfer) begin
        pkt_cnt <= o_tlast ? 16'd0 : pkt_cnt + 16'd1;
        vec_cnt <= last_out ? 16'd0 : vec_cnt + 16'd1;
        if (vec_cnt == 16'd0) n_out_lat <= n_out;
        if (last_out) vec_out_cnt <= vec_out_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_nnet_vector_framer.sv
// tb_nnet_vector_framer: table of framing configurations plus directed stall, settings, clear/reset and bypass sequences.
`timescale 1ns/1ps
module tb_nnet_vector_framer;
  logic clk = 1'b0;
  logic reset, clear, set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic [15:0] size_in, size_out;
  logic [31:0] i_tdata, o_tdata;
  logic i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
  logic [127:0] i_tuser, o_tuser;
  logic [17:0] m_tdata, s_tdata;
  logic m_tlast, m_tvalid, m_tready, s_tvalid, s_tready;
  logic [15:0] spp_out, vin_cnt, vout_cnt;
  logic [31:0] z_o_tdata;
  logic z_i_tready, z_o_tlast, z_o_tvalid, z_m_tlast, z_m_tvalid, z_s_tready;
  logic [127:0] z_o_tuser;
  logic [17:0] z_m_tdata;
  logic [15:0] z_spp_out, z_vin_cnt, z_vout_cnt;

  always #5 clk = ~clk;

  nnet_vector_framer dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .nnet_size_in(size_in), .nnet_size_out(size_out),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tuser(i_tuser),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .spp_out(spp_out), .vec_in_cnt(vin_cnt), .vec_out_cnt(vout_cnt)
  );

  nnet_vector_framer #(.SIGN_EXT(0)) dut_z (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .nnet_size_in(size_in), .nnet_size_out(size_out),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(z_i_tready), .i_tuser(i_tuser),
    .o_tdata(z_o_tdata), .o_tlast(z_o_tlast), .o_tvalid(z_o_tvalid), .o_tready(o_tready), .o_tuser(z_o_tuser),
    .m_axis_tdata(z_m_tdata), .m_axis_tlast(z_m_tlast), .m_axis_tvalid(z_m_tvalid), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(z_s_tready),
    .spp_out(z_spp_out), .vec_in_cnt(z_vin_cnt), .vec_out_cnt(z_vout_cnt)
  );

  // core stand-in: each completed input vector yields N_OUT sequential results
  int pend, res_val;
  logic force_max;
  assign s_tvalid = pend > 0;
  assign s_tdata = force_max ? 18'h3FFFF : 18'(res_val);
  always @(posedge clk) begin
    if (reset || clear) begin
      pend <= 0;
      res_val <= 0;
    end else begin
      pend <= pend + ((m_tvalid && m_tready && m_tlast) ? (size_out == 16'd0 ? 1 : int'(size_out)) : 0)
                   - ((s_tvalid && s_tready) ? 1 : 0);
      if (s_tvalid && s_tready) res_val <= res_val + 1;
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] zd;
    logic last;
    logic [127:0] user;
  } orec_t;
  orec_t out_q[$];
  logic mlast_q[$];
  always @(negedge clk) begin
    if (o_tvalid && o_tready) out_q.push_back(orec_t'({o_tdata, z_o_tdata, o_tlast, o_tuser}));
    if (m_tvalid && m_tready) mlast_q.push_back(m_tlast);
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] ufn(input int v);
    return {4'hB, 28'h0, 32'(v), 32'hC0DE0000 | 32'(v), 32'(v)};
  endfunction
  function automatic logic [127:0] expu(input int v, input logic e);
    logic [127:0] r;
    r = ufn(v);
    r[124] = e;
    return r;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    step();
    set_stb = 1'b0;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_q.delete();
    mlast_q.delete();
  endtask
  task automatic send(input int n, input int v0);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      i_tvalid = 1'b1;
      i_tdata = 32'(v0 + k);
      i_tuser = ufn(v0 + k);
      i_tlast = ((v0 + k) % 5) == 4;
      do begin
        @(negedge clk);
        t++;
      end while (!i_tready && t < 200);
      chk("send_accept", i_tready, 1'b1);
      step();
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask
  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 1000) begin
      step();
      t++;
    end
    step(4);
    chk("out_count", out_q.size(), n);
  endtask

  typedef struct packed {
    logic [15:0] n_in;
    logic [15:0] n_out;
    logic [15:0] spp;
    logic [3:0] nvec;
    logic [1:0] npk;
    logic [2:0][7:0] len;
    logic [2:0] eob;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t c;
    int ni, no, oi;
    tbl[0] = {16'd8, 16'd4, 16'd0, 4'd2, 2'd1, {8'd0, 8'd0, 8'd4}, 3'b001};
    tbl[1] = {16'd3, 16'd10, 16'd4, 4'd1, 2'd3, {8'd2, 8'd4, 8'd4}, 3'b100};
    tbl[2] = {16'd0, 16'd0, 16'd0, 4'd2, 2'd1, {8'd0, 8'd0, 8'd1}, 3'b001};
    tbl[3] = {16'd5, 16'd6, 16'd3, 4'd1, 2'd2, {8'd0, 8'd3, 8'd3}, 3'b010};
    tbl[4] = {16'd2, 16'd3, 16'd5, 4'd1, 2'd1, {8'd0, 8'd0, 8'd3}, 3'b001};
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    size_in = 16'd8; size_out = 16'd4; force_max = 1'b0; m_tready = 1'b1; o_tready = 1'b1;
    i_tvalid = 1'b1; i_tlast = 1'b1; i_tdata = 32'd0; i_tuser = ufn(0);
    step(3);
    chk("rst_o_tvalid", o_tvalid, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_i_tready", i_tready, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_o_tlast", o_tlast, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    i_tvalid = 1'b0; i_tlast = 1'b0;
    reset = 1'b0;
    step();
    chk("rst_spp", spp_out, 16'd0);
    chk("rst_vin", vin_cnt, 16'd0);
    chk("rst_vout", vout_cnt, 16'd0);
    out_q.delete(); mlast_q.delete();

    for (int r = 0; r < 5; r++) begin
      c = tbl[r];
      ni = (c.n_in == 16'd0) ? 1 : int'(c.n_in);
      no = (c.n_out == 16'd0) ? 1 : int'(c.n_out);
      size_in = c.n_in; size_out = c.n_out;
      wr(8'd131, 32'(c.spp));
      step(2);
      chk("row_spp_out", spp_out, c.spp);
      pulse_clear();
      send(ni * int'(c.nvec), 0);
      wait_out(no * int'(c.nvec));
      oi = 0;
      for (int v = 0; v < int'(c.nvec); v++)
        for (int p = 0; p < int'(c.npk); p++)
          for (int s = 0; s < int'(c.len[p]); s++) begin
            chk("row_data", out_q[oi].d, 32'(oi));
            chk("row_tlast", out_q[oi].last, s == int'(c.len[p]) - 1);
            chk("row_tuser", out_q[oi].user, expu(v * ni, c.eob[p]));
            oi++;
          end
      chk("row_m_count", mlast_q.size(), ni * int'(c.nvec));
      for (int k = 0; k < mlast_q.size(); k++) chk("row_m_tlast", mlast_q[k], (k % ni) == ni - 1);
      chk("row_vin", vin_cnt, c.nvec);
      chk("row_vout", vout_cnt, c.nvec);
    end

    // sign extension of an all-ones core result
    size_in = 16'd1; size_out = 16'd1;
    wr(8'd131, 32'd0);
    step(2);
    pulse_clear();
    force_max = 1'b1;
    send(1, 0);
    wait_out(1);
    chk("sext_on", out_q[0].d, 32'hFFFFFFFF);
    chk("sext_off", out_q[0].zd, 32'h0003FFFF);
    force_max = 1'b0;

    // header FIFO full: third vector stalls until the first output vector drains
    size_in = 16'd2; size_out = 16'd2;
    o_tready = 1'b0;
    pulse_clear();
    send(2, 0);
    send(2, 2);
    i_tvalid = 1'b1; i_tdata = 32'd4; i_tuser = ufn(4); i_tlast = 1'b0;
    step(6);
    chk("stall_ready", i_tready, 1'b0);
    chk("stall_noout", out_q.size(), 0);
    o_tready = 1'b1;
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!i_tready && t < 100);
    end
    chk("stall_release", i_tready, 1'b1);
    step();
    i_tvalid = 1'b0;
    chk("stall_drained", out_q.size(), 2);
    send(1, 5);
    wait_out(6);
    chk("stall_hdr3", out_q[4].user, expu(4, 1'b1));
    chk("stall_vout", vout_cnt, 16'd3);

    // SPP written mid-vector applies from the next vector only
    size_in = 16'd4; size_out = 16'd4;
    pulse_clear();
    send(2, 0);
    wr(8'd131, 32'd2);
    step(2);
    chk("spp_hold", spp_out, 16'd0);
    send(2, 2);
    wait_out(4);
    chk("spp_old_mid", out_q[1].last, 1'b0);
    chk("spp_old_end", out_q[3].last, 1'b1);
    chk("spp_new_active", spp_out, 16'd2);
    send(4, 4);
    wait_out(8);
    chk("spp_new_p1", out_q[5].last, 1'b1);
    chk("spp_new_eob0", out_q[4].user[124], 1'b0);
    chk("spp_new_eob1", out_q[6].user[124], 1'b1);
    chk("spp_new_hdr", out_q[7].user, expu(4, 1'b1));
    wr(8'd131, 32'd0);
    step(2);

    // clear after 3 of 8 samples
    size_in = 16'd8; size_out = 16'd8;
    pulse_clear();
    send(8, 0);
    wait_out(8);
    chk("clr_vin_pre", vin_cnt, 16'd1);
    send(3, 8);
    pulse_clear();
    chk("clr_vin", vin_cnt, 16'd0);
    chk("clr_vout", vout_cnt, 16'd0);
    step(10);
    chk("clr_noout", out_q.size(), 0);
    send(8, 20);
    wait_out(8);
    chk("clr_hdr", out_q[0].user, expu(20, 1'b1));
    chk("clr_last6", out_q[6].last, 1'b0);
    chk("clr_last7", out_q[7].last, 1'b1);
    chk("clr_vin_post", vin_cnt, 16'd1);

    // reset after 3 of 8 samples
    send(3, 40);
    reset = 1'b1;
    i_tvalid = 1'b1; i_tdata = 32'd43; i_tuser = ufn(43);
    step();
    chk("mrst_i_tready", i_tready, 1'b0);
    chk("mrst_m_tvalid", m_tvalid, 1'b0);
    chk("mrst_m_tlast", m_tlast, 1'b0);
    chk("mrst_o_tvalid", o_tvalid, 1'b0);
    i_tvalid = 1'b0;
    reset = 1'b0;
    out_q.delete(); mlast_q.delete();
    chk("mrst_vin", vin_cnt, 16'd0);
    step(10);
    chk("mrst_noout", out_q.size(), 0);
    send(8, 60);
    wait_out(8);
    chk("mrst_hdr", out_q[0].user, expu(60, 1'b1));
    chk("mrst_m_last6", mlast_q[6], 1'b0);
    chk("mrst_m_last7", mlast_q[7], 1'b1);
    chk("mrst_vout", vout_cnt, 16'd1);

    // bypass passes i_* straight through and leaves the core side idle
    wr(8'd132, 32'd1);
    step(2);
    o_tready = 1'b0;
    i_tvalid = 1'b1; i_tdata = 32'h12345678; i_tuser = ufn(99); i_tlast = 1'b1;
    step();
    chk("byp_o_tvalid", o_tvalid, 1'b1);
    chk("byp_o_tdata", o_tdata, 32'h12345678);
    chk("byp_o_tuser", o_tuser, ufn(99));
    chk("byp_o_tlast", o_tlast, 1'b1);
    chk("byp_i_tready0", i_tready, 1'b0);
    chk("byp_m_tvalid", m_tvalid, 1'b0);
    o_tready = 1'b1;
    step();
    chk("byp_i_tready1", i_tready, 1'b1);
    step(3);
    chk("byp_vin_hold", vin_cnt, 16'd1);
    i_tvalid = 1'b0; i_tlast = 1'b0;
    wr(8'd132, 32'd0);
    step(2);
    chk("byp_off", o_tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
